// File: rtl/arm_regfile_pkg.sv
// Shared constants and types for the multi-port ARM register file.
package arm_regfile_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 4;
   localparam int unsigned NUM_RD_DEF = 3;

   typedef logic [ADDR_W_DEF-1:0] reg_idx_t;
   typedef logic [DATA_W_DEF-1:0] word_t;

endpackage

// File: rtl/arm_regfile_rdport.sv
// One registered read port: write-forwarding priority mux plus busy lookup.
module arm_regfile_rdport
   import arm_regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter bit          BYPASS = 1'b1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        stored,
   input  logic                     wr0_en,
   input  logic [ADDR_W-1:0]        wr0_addr,
   input  logic [DATA_W-1:0]        wr0_data,
   input  logic                     wr1_en,
   input  logic [ADDR_W-1:0]        wr1_addr,
   input  logic [DATA_W-1:0]        wr1_data,
   input  logic [(1<<ADDR_W)-1:0]   busy_nxt,
   output logic [DATA_W-1:0]        data,
   output logic                     busy
);

   logic [DATA_W-1:0] sel_c;

   // Forwarding mux: wr1 outranks wr0, matching the storage collision rule.
   always_comb begin
      sel_c = stored;
      if (BYPASS) begin
         if (wr1_en && (wr1_addr == addr)) begin
            sel_c = wr1_data;
         end else if (wr0_en && (wr0_addr == addr)) begin
            sel_c = wr0_data;
         end
      end
   end

   // Output registers; busy reflects the post-edge scoreboard.
   always_ff @(posedge clk) begin
      if (reset) begin
         data <= '0;
         busy <= 1'b0;
      end else begin
         data <= sel_c;
         busy <= busy_nxt[addr];
      end
   end

endmodule

// File: rtl/arm_regfile_mp.sv
// Multi-port register file: NUM_RD read ports, two write ports, busy scoreboard.
module arm_regfile_mp
   import arm_regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = NUM_RD_DEF,
   parameter bit          BYPASS = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wr0_en,
   input  logic [ADDR_W-1:0]          wr0_addr,
   input  logic [DATA_W-1:0]          wr0_data,
   input  logic                       wr0_clr,
   input  logic                       wr1_en,
   input  logic [ADDR_W-1:0]          wr1_addr,
   input  logic [DATA_W-1:0]          wr1_data,
   input  logic                       wr1_clr,
   input  logic                       sb_set_en,
   input  logic [ADDR_W-1:0]          sb_set_addr,
   output logic                       any_busy
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DEPTH-1:0]  busy;
   logic [DEPTH-1:0]  busy_nxt_c;

   // Storage; on an address collision wr0 is suppressed so wr1 lands.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem <= '{default: '0};
      end else begin
         if (wr0_en && !(wr1_en && (wr1_addr == wr0_addr))) begin
            mem[wr0_addr] <= wr0_data;
         end
         if (wr1_en) begin
            mem[wr1_addr] <= wr1_data;
         end
      end
   end

   // Scoreboard next state: clears first, then set so a new issue owns the register.
   always_comb begin
      busy_nxt_c = busy;
      if (wr0_en && wr0_clr) begin
         busy_nxt_c[wr0_addr] = 1'b0;
      end
      if (wr1_en && wr1_clr) begin
         busy_nxt_c[wr1_addr] = 1'b0;
      end
      if (sb_set_en) begin
         busy_nxt_c[sb_set_addr] = 1'b1;
      end
   end

   // Scoreboard and summary flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy     <= '0;
         any_busy <= 1'b0;
      end else begin
         busy     <= busy_nxt_c;
         any_busy <= |busy_nxt_c;
      end
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      assign addr = rd_addr[k*ADDR_W +: ADDR_W];

      arm_regfile_rdport #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .BYPASS (BYPASS)
      ) u_rdport (
         .clk      (clk),
         .reset    (reset),
         .addr     (addr),
         .stored   (mem[addr]),
         .wr0_en   (wr0_en),
         .wr0_addr (wr0_addr),
         .wr0_data (wr0_data),
         .wr1_en   (wr1_en),
         .wr1_addr (wr1_addr),
         .wr1_data (wr1_data),
         .busy_nxt (busy_nxt_c),
         .data     (rd_data[k*DATA_W +: DATA_W]),
         .busy     (rd_busy[k])
      );
   end

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Bench for arm_regfile_mp: bypass and non-bypass builds against a behavioural model.
module tb_arm_regfile_mp;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] rd_addr;
   logic [95:0] rd_data_b, rd_data_n;
   logic [2:0]  rd_busy_b, rd_busy_n;
   logic        wr0_en, wr0_clr, wr1_en, wr1_clr, sb_set_en;
   logic [3:0]  wr0_addr, wr1_addr, sb_set_addr;
   logic [31:0] wr0_data, wr1_data;
   logic        any_busy_b, any_busy_n;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_mem [16];
   logic [15:0] m_busy;

   always #5 clk = ~clk;

   arm_regfile_mp #(.BYPASS(1'b1)) dut_b (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_clr(wr0_clr),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_clr(wr1_clr),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .any_busy(any_busy_b));

   arm_regfile_mp #(.BYPASS(1'b0)) dut_n (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_clr(wr0_clr),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_clr(wr1_clr),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .any_busy(any_busy_n));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic idle();
      reset = 1'b0; rd_addr = '0;
      wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0; wr0_clr = 1'b0;
      wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0; wr1_clr = 1'b0;
      sb_set_en = 1'b0; sb_set_addr = '0;
   endtask

   task automatic rd_all(input logic [3:0] a);
      rd_addr = {a, a, a};
   endtask

   // Advance one clock with the current inputs and check both builds against the model.
   task automatic cyc();
      logic [31:0] e_b [3];
      logic [31:0] e_n [3];
      logic [2:0]  e_busy;
      logic [15:0] nb;
      logic [3:0]  a;
      if (reset) begin
         for (int k = 0; k < 3; k++) begin e_b[k] = '0; e_n[k] = '0; end
         e_busy = '0;
         for (int r = 0; r < 16; r++) m_mem[r] = '0;
         m_busy = '0;
      end else begin
         nb = m_busy;
         if (wr0_en && wr0_clr) nb[wr0_addr] = 1'b0;
         if (wr1_en && wr1_clr) nb[wr1_addr] = 1'b0;
         if (sb_set_en) nb[sb_set_addr] = 1'b1;
         for (int k = 0; k < 3; k++) begin
            a = rd_addr[k*4 +: 4];
            e_n[k] = m_mem[a];
            if (wr1_en && wr1_addr == a)      e_b[k] = wr1_data;
            else if (wr0_en && wr0_addr == a) e_b[k] = wr0_data;
            else                              e_b[k] = m_mem[a];
            e_busy[k] = nb[a];
         end
         if (wr0_en) m_mem[wr0_addr] = wr0_data;
         if (wr1_en) m_mem[wr1_addr] = wr1_data;
         m_busy = nb;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rd_data_byp[%0d]", k), rd_data_b[k*32 +: 32], e_b[k]);
         chk($sformatf("rd_data_nobyp[%0d]", k), rd_data_n[k*32 +: 32], e_n[k]);
         chk($sformatf("rd_busy_byp[%0d]", k), 32'(rd_busy_b[k]), 32'(e_busy[k]));
         chk($sformatf("rd_busy_nobyp[%0d]", k), 32'(rd_busy_n[k]), 32'(e_busy[k]));
      end
      chk("any_busy_byp", 32'(any_busy_b), 32'(|m_busy));
      chk("any_busy_nobyp", 32'(any_busy_n), 32'(|m_busy));
   endtask

   initial begin
      for (int r = 0; r < 16; r++) m_mem[r] = '0;
      m_busy = '0;

      // Initial reset
      idle(); reset = 1'b1; cyc(); cyc();

      // Reset: preload r3, mark busy, then reset clears everything
      idle(); wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 32'hDEADBEEF; sb_set_en = 1'b1; sb_set_addr = 4'd3; cyc();
      idle(); rd_all(4'd3); cyc();
      chk("preload_r3", rd_data_n[31:0], 32'hDEADBEEF);
      chk("preload_busy_r3", 32'(rd_busy_b[0]), 32'd1);
      idle(); reset = 1'b1; rd_all(4'd3); wr1_en = 1'b1; wr1_addr = 4'd3; wr1_data = 32'h5; cyc();
      chk("reset_rd_data", rd_data_b[31:0], 32'd0);
      idle(); rd_all(4'd3); cyc();
      chk("post_reset_r3", rd_data_b[95:64], 32'd0);

      // Basic write then read on all ports
      idle(); wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 32'h12345678; cyc();
      idle(); rd_all(4'd5); cyc();
      chk("basic_r5", rd_data_n[63:32], 32'h12345678);

      // Bypass: write and read r7 in the same cycle, then read again
      idle(); wr1_en = 1'b1; wr1_addr = 4'd7; wr1_data = 32'hA5A5A5A5; rd_all(4'd7); cyc();
      chk("bypass_r7", rd_data_b[31:0], 32'hA5A5A5A5);
      chk("nobypass_old_r7", rd_data_n[31:0], 32'd0);
      idle(); rd_all(4'd7); cyc();

      // Collision: wr1 wins, both forwarded and stored
      idle(); wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 32'h1111;
      wr1_en = 1'b1; wr1_addr = 4'd2; wr1_data = 32'h2222; rd_all(4'd2); cyc();
      chk("collision_bypass", rd_data_b[31:0], 32'h2222);
      idle(); rd_all(4'd2); cyc();
      chk("collision_stored", rd_data_n[31:0], 32'h2222);

      // Scoreboard set, clear via wr0, set beats same-cycle clear
      idle(); sb_set_en = 1'b1; sb_set_addr = 4'd9; rd_all(4'd9); cyc();
      chk("sb_set_r9", 32'(rd_busy_b[1]), 32'd1);
      chk("sb_any_busy", 32'(any_busy_b), 32'd1);
      idle(); wr0_en = 1'b1; wr0_addr = 4'd9; wr0_data = 32'h9; wr0_clr = 1'b1; rd_all(4'd9); cyc();
      chk("sb_clr_r9", 32'(rd_busy_b[2]), 32'd0);
      idle(); sb_set_en = 1'b1; sb_set_addr = 4'd9;
      wr1_en = 1'b1; wr1_addr = 4'd9; wr1_data = 32'h99; wr1_clr = 1'b1; rd_all(4'd9); cyc();
      chk("sb_set_beats_clr", 32'(rd_busy_n[0]), 32'd1);

      // Clear gating: clr without en leaves r4 busy and unchanged
      idle(); sb_set_en = 1'b1; sb_set_addr = 4'd4; cyc();
      idle(); wr0_clr = 1'b1; wr0_addr = 4'd4; wr0_data = 32'hFFFF0000; rd_all(4'd4); cyc();
      chk("clr_gated_busy", 32'(rd_busy_b[0]), 32'd1);
      chk("clr_gated_data", rd_data_b[31:0], 32'd0);

      // Randomized traffic, narrow address range to provoke collisions
      for (int i = 0; i < 400; i++) begin
         idle();
         reset       = ($urandom_range(0, 59) == 0);
         rd_addr     = 12'($urandom);
         if ($urandom_range(0, 1) == 1) rd_addr[3:0] = rd_addr[7:4];
         wr0_en      = 1'($urandom);
         wr0_addr    = 4'($urandom_range(0, 7));
         wr0_data    = $urandom;
         wr0_clr     = 1'($urandom);
         wr1_en      = 1'($urandom);
         wr1_addr    = 4'($urandom_range(0, 7));
         wr1_data    = $urandom;
         wr1_clr     = 1'($urandom);
         sb_set_en   = ($urandom_range(0, 2) != 0);
         sb_set_addr = 4'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) rd_addr[11:8] = wr0_addr;
         if ($urandom_range(0, 3) == 0) rd_addr[7:4]  = wr1_addr;
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arm_regfile_mp.md
# arm_regfile_mp

Parametrised multi-port register file for the 32-bit ARM core: the successor to the single-write, dual-read file. It provides NUM_RD registered read ports and two write ports (ALU result and load/writeback). It adds optional write-to-read bypass and a per-register busy scoreboard that the issue stage uses for hazard detection. It sits between decode/issue (reads, scoreboard set) and writeback (writes, scoreboard clear).

## Interface
- DATA_W, 32: register width in bits.
- ADDR_W, 4: register index width; depth = 2**ADDR_W.
- NUM_RD, 3: number of read ports (≥1).
- BYPASS, 1: 1 = same-cycle write data forwarded to matching reads; 0 = reads return pre-write contents.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port k at bits [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  registered read data; port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  registered busy bit of the addressed register, per port.
- wr0_en  in  1  write port 0 enable (ALU).
- wr0_addr  in  ADDR_W  write port 0 index.
- wr0_data  in  DATA_W  write port 0 data.
- wr0_clr  in  1  when wr0_en is high, clear busy[wr0_addr].
- wr1_en, wr1_addr, wr1_data, wr1_clr  in  1/ADDR_W/DATA_W/1  write port 1 (load/writeback), same meaning.
- sb_set_en  in  1  mark a register busy (instruction issued).
- sb_set_addr  in  ADDR_W  index to mark busy.
- any_busy  out  1  registered OR of all busy bits.

## Operation
- Storage: 2**ADDR_W × DATA_W registers plus a 2**ADDR_W busy vector.
- Reads: on each clk, rd_data[k] <= selected value for rd_addr[k], and rd_busy[k] <= next-state busy[rd_addr[k]]. All ports are independent. Identical addresses on several ports are legal.
- Write selection per read port (BYPASS=1): wr1 match → wr1_data; else wr0 match → wr0_data; else stored value. A match means en high and addr equal. BYPASS=0: always the stored value before this edge's writes.
- Writes: wr0 and wr1 to different indices both commit. Same index with both enabled: wr1_data is stored and wr0_data is dropped.
- Scoreboard per register r, evaluated in this order: clear if (wr0_en&wr0_clr&wr0_addr==r) or (wr1_en&wr1_clr&wr1_addr==r); then set if sb_set_en&sb_set_addr==r. Set wins over a same-cycle clear, because the newly issued instruction owns r.
- wrN_clr with wrN_en low is ignored. Writes with clr low leave busy unchanged.
- any_busy <= OR of next-state busy vector.

## Timing
- Read latency 1 cycle: address presented in cycle n, data valid after edge n+1, held until the next edge.
- Write visible in storage after the edge. With BYPASS=1 it is also visible to reads presented in the same cycle; with BYPASS=0 it is visible from the following cycle.
- Scoreboard set/clear take effect at the edge. rd_busy for a same-cycle read reflects the post-edge value.
- Reset (synchronous, takes priority over all inputs): all registers 0, busy vector 0, rd_data 0, rd_busy 0, any_busy 0. Writes and sb_set presented during reset are discarded. Reset mid-stream needs no drain; operation resumes the cycle after reset deasserts.
- No combinational path from any input to any output.

## Structure
- Package arm_regfile_pkg: default DATA_W/ADDR_W/NUM_RD constants, register-index typedef, data-word typedef.
- Sub-module arm_regfile_rdport: one registered read port (bypass priority mux + busy lookup). Instantiate it NUM_RD times in a generate loop.
- Storage, write-collision logic and scoreboard stay in the top module.

## Test plan
- Reset: preload r3=0xDEADBEEF, set busy r3, assert reset 1 cycle → rd_data=0 for all ports, rd_busy=0, any_busy=0; read r3 → 0.
- Basic: write r5=0x12345678 via wr0, then read r5 on all 3 ports next cycle → all return 0x12345678 one cycle after the address.
- Bypass: BYPASS=1, wr1 r7=0xA5A5A5A5 and read r7 in the same cycle → 0xA5A5A5A5 next cycle. BYPASS=0 build → old value, then 0xA5A5A5A5 on the following read.
- Write collision: wr0 r2=0x1111, wr1 r2=0x2222 in the same cycle → read r2 returns 0x2222, both in bypass and after commit.
- Scoreboard: sb_set r9 → rd_busy=1 and any_busy=1. wr0 r9 with clr → busy 0. Same-cycle sb_set r9 plus wr1 clr r9 → busy stays 1.
- Clear gating: wr0_clr=1 with wr0_en=0 on busy r4 → r4 remains busy and data unchanged.
